// File: rtl/set_assoc_tag_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : set_assoc_tag_unit_if
// Purpose  : Request / response / fill bundle between the cache controller
//            (master) and the set-associative tag unit (slave).
// Revision : 1.0  initial release
// ============================================================================
interface set_assoc_tag_unit_if #(
  parameter int TAG_W   = 3,
  parameter int INDEX_W = 3,
  parameter int WAY_W   = 1
);
  logic               req_valid;
  logic               req_write;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic               busy;
  logic               resp_valid;
  logic               resp_hit;
  logic [WAY_W-1:0]   resp_way;
  logic               victim_valid;
  logic               victim_dirty;
  logic [TAG_W-1:0]   victim_tag;
  logic               fill_valid;
  logic               fill_done;

  modport master (
    output req_valid, req_write, req_tag, req_index, fill_valid,
    input  busy, resp_valid, resp_hit, resp_way,
    input  victim_valid, victim_dirty, victim_tag, fill_done
  );

  modport slave (
    input  req_valid, req_write, req_tag, req_index, fill_valid,
    output busy, resp_valid, resp_hit, resp_way,
    output victim_valid, victim_dirty, victim_tag, fill_done
  );
endinterface
`default_nettype wire

// File: rtl/set_assoc_tag_unit.sv
`default_nettype none
// ============================================================================
// Module   : set_assoc_tag_unit
// Purpose  : Registered tag lookup for a 2^INDEX_W-set x WAYS-way cache.
//            Reports hit/miss and the hit or victim way, then installs the
//            new tag once the controller signals the fill.
// Options  : TAG_STATS_EN adds saturating hit_count / miss_count outputs.
// Revision : 1.0  initial release
// ============================================================================
module set_assoc_tag_unit #(
  parameter int TAG_W   = 3,
  parameter int INDEX_W = 3,
  parameter int WAYS    = 2,
  parameter int WAY_W   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  set_assoc_tag_unit_if.slave  bus
`ifdef TAG_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);

  localparam int SETS = 1 << INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMPARE   = 2'd1,
    S_MISS_WAIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Per-set line state
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [WAY_W-1:0] rr_q    [SETS];

  // Captured request and miss context
  logic [TAG_W-1:0]   req_tag_q;
  logic [INDEX_W-1:0] req_index_q;
  logic               req_write_q;
  logic [WAY_W-1:0]   victim_way_q;
  logic               all_valid_q;

  // Registered outputs
  logic               resp_valid_q, resp_hit_q, fill_done_q;
  logic [WAY_W-1:0]   resp_way_q;
  logic               victim_valid_q, victim_dirty_q;
  logic [TAG_W-1:0]   victim_tag_q;

  // Lookup results for the registered set
  logic               hit, free;
  logic [WAY_W-1:0]   hit_way, free_way, victim_way;
  logic               accept, compare, fill;

  // Parallel compare; scanning from the top leaves the lowest match/free way
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    free     = 1'b0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_index_q][w] && (tag_q[req_index_q][w] == req_tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_index_q][w]) begin
        free     = 1'b1;
        free_way = WAY_W'(w);
      end
    end
    victim_way = free ? free_way : rr_q[req_index_q];
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and datapath strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    compare = 1'b0;
    fill    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        compare = 1'b1;
        state_d = hit ? S_IDLE : S_MISS_WAIT;
      end
      S_MISS_WAIT: begin
        if (bus.fill_valid) begin
          fill    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, response registers and valid/dirty/round-robin state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_tag_q      <= '0;
      req_index_q    <= '0;
      req_write_q    <= 1'b0;
      victim_way_q   <= '0;
      all_valid_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_way_q     <= '0;
      victim_valid_q <= 1'b0;
      victim_dirty_q <= 1'b0;
      victim_tag_q   <= '0;
      fill_done_q    <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      resp_valid_q <= compare;
      fill_done_q  <= fill;
      if (accept) begin
        req_tag_q   <= bus.req_tag;
        req_index_q <= bus.req_index;
        req_write_q <= bus.req_write;
      end
      if (compare) begin
        resp_hit_q <= hit;
        if (hit) begin
          resp_way_q     <= hit_way;
          victim_valid_q <= 1'b0;
          victim_dirty_q <= 1'b0;
          victim_tag_q   <= '0;
          if (req_write_q) dirty_q[req_index_q][hit_way] <= 1'b1;
        end else begin
          resp_way_q     <= victim_way;
          victim_valid_q <= valid_q[req_index_q][victim_way];
          victim_dirty_q <= dirty_q[req_index_q][victim_way];
          victim_tag_q   <= tag_q[req_index_q][victim_way];
          victim_way_q   <= victim_way;
          all_valid_q    <= ~free;
        end
      end
      if (fill) begin
        valid_q[req_index_q][victim_way_q] <= 1'b1;
        dirty_q[req_index_q][victim_way_q] <= req_write_q;
        // Only a forced eviction advances the pointer; direct-mapped keeps it at 0
        if (all_valid_q && (WAYS > 1)) rr_q[req_index_q] <= rr_q[req_index_q] + WAY_W'(1);
      end
    end
  end

  // Tag array has no reset; its contents only matter once valid is set
  always_ff @(posedge clock) begin
    if (fill) tag_q[req_index_q][victim_way_q] <= req_tag_q;
  end

`ifdef TAG_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  // Saturating lookup statistics, counted on the response edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (compare) begin
      if (hit && (hit_cnt_q != 16'hFFFF))   hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (!hit && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  assign bus.busy         = (state_q != S_IDLE);
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_hit     = resp_hit_q;
  assign bus.resp_way     = resp_way_q;
  assign bus.victim_valid = victim_valid_q;
  assign bus.victim_dirty = victim_dirty_q;
  assign bus.victim_tag   = victim_tag_q;
  assign bus.fill_done    = fill_done_q;

endmodule
`default_nettype wire
